rgb_to_binary: RTL and testbench

Streaming binariser, the reverse of the binary-to-RGB path. It accepts one RGB pixel per handshake and computes an 8-bit luma. It compares the luma against a programmable threshold and emits one binary image pixel, 0x00 or 0xFF. It tracks the raster position over a WIDTH x HEIGHT frame and flags start-of-frame, end-of-line and end-of-frame, so downstream blocks can rebuild the image array.

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/raster_counter.sv | 53 +++++
 rtl/rgb_to_binary.sv | 103 ++++++++++
 tb/tb_rgb_to_binary.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Pixel format constants and luma arithmetic shared by the RGB <-> binary paths.
package pixel_pkg;

    localparam int PIX_W      = 8;
    localparam int SUM_W      = 16;
    localparam int LUMA_SHIFT = 8;

    localparam logic [SUM_W-1:0] COEF_R = 16'd77;
    localparam logic [SUM_W-1:0] COEF_G = 16'd150;
    localparam logic [SUM_W-1:0] COEF_B = 16'd29;

    localparam logic [PIX_W-1:0] BIN_HI_DEF = 8'hFF;
    localparam logic [PIX_W-1:0] BIN_LO_DEF = 8'h00;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_pixel_t;

    // Coefficients sum to 256, so the weighted sum tops out at 65280 and fits 16 bits.
    function automatic logic [SUM_W-1:0] luma_sum(input rgb_pixel_t px);
        return COEF_R * {8'd0, px.r} + COEF_G * {8'd0, px.g} + COEF_B * {8'd0, px.b};
    endfunction

    function automatic logic [PIX_W-1:0] luma_of(input rgb_pixel_t px);
        return PIX_W'(luma_sum(px) >> LUMA_SHIFT);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column tracker for a WIDTH x HEIGHT raster; steps one pixel per advance.
module raster_counter #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;
    assign sof = (row_q == '0) && (col_q == '0);
    assign eol = (col_q == COL_LAST);
    assign eof = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/rgb_to_binary.sv
// Streaming RGB -> binary pixel thresholder with raster position tagging.
// Valid/ready: a beat moves when valid & ready are both high at the rising edge; a producer holds its data while valid & !ready.
module rgb_to_binary
    import pixel_pkg::*;
#(
    parameter int               WIDTH  = 10,
    parameter int               HEIGHT = 10,
    parameter logic [PIX_W-1:0] BIN_HI = BIN_HI_DEF,
    parameter logic [PIX_W-1:0] BIN_LO = BIN_LO_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_W-1:0]          threshold,
    input  logic [PIX_W-1:0]          rgb_pixel_r,
    input  logic [PIX_W-1:0]          rgb_pixel_g,
    input  logic [PIX_W-1:0]          rgb_pixel_b,
    input  logic                      rgb_pixel_valid,
    output logic                      rgb_pixel_ready,
    output logic [PIX_W-1:0]          binary_image_pixel,
    output logic                      binary_pixel_valid,
    input  logic                      binary_pixel_ready,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof
);

    rgb_pixel_t in_px;

    logic             s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0] s1_luma_q, s1_luma_d;
    logic [PIX_W-1:0] s1_thr_q, s1_thr_d;
    logic             s2_valid_q, s2_valid_d;
    logic [PIX_W-1:0] s2_pix_q, s2_pix_d;
    logic             s2_ready;
    logic             sof_raw, eol_raw, eof_raw;

    assign in_px = '{r: rgb_pixel_r, g: rgb_pixel_g, b: rgb_pixel_b};

    // Each stage accepts when empty or when its contents leave this cycle.
    assign s2_ready        = !s2_valid_q || binary_pixel_ready;
    assign rgb_pixel_ready = !s1_valid_q || s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_luma_d  = s1_luma_q;
        s1_thr_d   = s1_thr_q;
        s2_valid_d = s2_valid_q;
        s2_pix_d   = s2_pix_q;
        if (rgb_pixel_ready) begin
            s1_valid_d = rgb_pixel_valid;
            if (rgb_pixel_valid) begin
                s1_luma_d = luma_of(in_px);
                s1_thr_d  = threshold;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pix_d = (s1_luma_q >= s1_thr_q) ? BIN_HI : BIN_LO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_luma_q  <= '0;
            s1_thr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_pix_q   <= 8'h00;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_luma_q  <= s1_luma_d;
            s1_thr_q   <= s1_thr_d;
            s2_valid_q <= s2_valid_d;
            s2_pix_q   <= s2_pix_d;
        end
    end

    // Position belongs to the presented pixel, so it only steps on an output transfer.
    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .advance (s2_valid_q && binary_pixel_ready),
        .row     (out_row),
        .col     (out_col),
        .sof     (sof_raw),
        .eol     (eol_raw),
        .eof     (eof_raw)
    );

    assign binary_image_pixel = s2_pix_q;
    assign binary_pixel_valid = s2_valid_q;
    assign out_sof            = s2_valid_q && sof_raw;
    assign out_eol            = s2_valid_q && eol_raw;
    assign out_eof            = s2_valid_q && eof_raw;

endmodule

// File: tb/tb_rgb_to_binary.sv
// Directed + randomized bench for rgb_to_binary against a luma/threshold model and raster index model.
module tb_rgb_to_binary;

    localparam int W = 10;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] threshold = '0;
    logic [7:0] rgb_pixel_r = '0;
    logic [7:0] rgb_pixel_g = '0;
    logic [7:0] rgb_pixel_b = '0;
    logic       rgb_pixel_valid = 1'b0;
    logic       rgb_pixel_ready;
    logic [7:0] binary_image_pixel;
    logic       binary_pixel_valid;
    logic       binary_pixel_ready = 1'b1;
    logic [3:0] out_row;
    logic [3:0] out_col;
    logic       out_sof, out_eol, out_eof;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_cnt = 0;
    int eof_cnt = 0;
    logic [7:0] exp_q[$];
    int pop_cyc[$];

    rgb_to_binary #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk                (clk),
        .rst                (rst),
        .threshold          (threshold),
        .rgb_pixel_r        (rgb_pixel_r),
        .rgb_pixel_g        (rgb_pixel_g),
        .rgb_pixel_b        (rgb_pixel_b),
        .rgb_pixel_valid    (rgb_pixel_valid),
        .rgb_pixel_ready    (rgb_pixel_ready),
        .binary_image_pixel (binary_image_pixel),
        .binary_pixel_valid (binary_pixel_valid),
        .binary_pixel_ready (binary_pixel_ready),
        .out_row            (out_row),
        .out_col            (out_col),
        .out_sof            (out_sof),
        .out_eol            (out_eol),
        .out_eof            (out_eof)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer luma of the weighted sum, then threshold compare.
    function automatic logic [7:0] ref_bin(input int r, input int g, input int b, input int thr);
        int luma;
        luma = (77 * r + 150 * g + 29 * b) / 256;
        return (luma >= thr) ? 8'hFF : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Scoreboard: push on input transfer, compare every presented output, pop on output transfer.
    always @(negedge clk) begin
        int k, er, ec;
        if (rst) begin
            exp_q.delete();
            out_cnt = 0;
        end else begin
            if (binary_pixel_valid) begin
                k  = out_cnt % (W * H);
                er = k / W;
                ec = k % W;
                chk("out_has_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("out_pixel", binary_image_pixel, exp_q[0]);
                chk("out_row", out_row, er);
                chk("out_col", out_col, ec);
                chk("out_sof", out_sof, 32'(k == 0));
                chk("out_eol", out_eol, 32'(ec == W - 1));
                chk("out_eof", out_eof, 32'(k == W * H - 1));
                if (binary_pixel_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (out_eof) eof_cnt++;
                    out_cnt++;
                    pop_cyc.push_back(cyc);
                end
            end
            if (rgb_pixel_valid && rgb_pixel_ready)
                exp_q.push_back(ref_bin(rgb_pixel_r, rgb_pixel_g, rgb_pixel_b, threshold));
        end
    end

    // Driver tasks: called at posedge+1, return at the next posedge+1.
    task automatic step_pixel(input logic v, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [7:0] t, output logic acc);
        rgb_pixel_valid = v;
        rgb_pixel_r     = r;
        rgb_pixel_g     = g;
        rgb_pixel_b     = b;
        threshold       = t;
        @(negedge clk);
        acc = v && rgb_pixel_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rgb_pixel_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_one(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] t, output logic [7:0] pix, output logic sof,
                            output int lat);
        logic acc;
        int n;
        n = 0;
        lat = -1;
        pix = 'x;
        sof = 'x;
        do begin
            step_pixel(1'b1, r, g, b, t, acc);
            n++;
        end while (!acc && n < 20);
        rgb_pixel_valid = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (binary_pixel_valid) begin
                pix = binary_image_pixel;
                sof = out_sof;
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && !binary_pixel_valid) break;
            step_pixel(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, acc);
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pix, pr, pg, pb, pt;
        logic       sof, acc, found;
        int         lat, n0, sent;

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", binary_pixel_valid, 0);
        chk("rst_pixel", binary_image_pixel, 8'h00);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_flags", {out_sof, out_eol, out_eof}, 0);
        chk("rst_in_ready", rgb_pixel_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First pixel: luma 200 vs 128
        send_one(8'd200, 8'd200, 8'd200, 8'd128, pix, sof, lat);
        chk("t1_pixel", pix, 8'hFF);
        chk("t1_sof", sof, 1);
        chk("t1_latency", lat, 2);

        // Red only (luma 76) then equality case (luma 128)
        send_one(8'd255, 8'd0, 8'd0, 8'd128, pix, sof, lat);
        chk("t2_red", pix, 8'h00);
        send_one(8'd128, 8'd128, 8'd128, 8'd128, pix, sof, lat);
        chk("t2_equal", pix, 8'hFF);

        // 100 random pixels, full throughput, frame wrap
        do_reset();
        pop_cyc.delete();
        eof_cnt = 0;
        binary_pixel_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pr = 8'($urandom_range(0, 255));
            pg = 8'($urandom_range(0, 255));
            pb = 8'($urandom_range(0, 255));
            pt = 8'($urandom_range(0, 255));
            step_pixel(1'b1, pr, pg, pb, pt, acc);
            chk("stream_accept", acc, 1);
        end
        rgb_pixel_valid = 1'b0;
        drain();
        chk("stream_count", pop_cyc.size(), 100);
        if (pop_cyc.size() > 0) chk("stream_span", pop_cyc[$] - pop_cyc[0], 99);
        chk("stream_eof_count", eof_cnt, 1);
        chk("stream_wrap_row", out_row, 0);
        chk("stream_wrap_col", out_col, 0);
        pr = 8'($urandom_range(0, 255));
        pt = 8'($urandom_range(0, 255));
        send_one(pr, pr, 8'd10, pt, pix, sof, lat);
        chk("p101_sof", sof, 1);
        chk("p101_pixel", pix, ref_bin(pr, pr, 10, pt));

        // Output stall for 5 cycles under a continuous input stream
        drain();
        n0 = pop_cyc.size();
        binary_pixel_ready = 1'b0;
        sent = 0;
        pr = 8'($urandom_range(0, 255));
        pt = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) begin
            step_pixel(1'b1, pr, 8'(255 - pr), pr, pt, acc);
            if (acc) begin
                sent++;
                pr = 8'($urandom_range(0, 255));
                pt = 8'($urandom_range(0, 255));
            end
        end
        chk("stall_accepted", sent, 2);
        chk("stall_in_ready", rgb_pixel_ready, 0);
        chk("stall_no_pop", pop_cyc.size() - n0, 0);
        binary_pixel_ready = 1'b1;
        for (int i = 0; i < 30 && sent < 8; i++) begin
            step_pixel(1'b1, pr, 8'(255 - pr), pr, pt, acc);
            if (acc) begin
                sent++;
                pr = 8'($urandom_range(0, 255));
                pt = 8'($urandom_range(0, 255));
            end
        end
        rgb_pixel_valid = 1'b0;
        drain();
        chk("stall_total_pops", pop_cyc.size() - n0, 8);

        // Reset with both stages full while presenting (3,4)
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step_pixel(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acc);
            if (binary_pixel_valid && out_row == 4'd3 && out_col == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_3_4", found, 1);
        rgb_pixel_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", binary_pixel_valid, 0);
        chk("mid_rst_row", out_row, 0);
        chk("mid_rst_col", out_col, 0);
        chk("mid_rst_in_ready", rgb_pixel_ready, 1);
        @(posedge clk);
        #1;
        send_one(8'd50, 8'd60, 8'd70, 8'd20, pix, sof, lat);
        chk("post_rst_sof", sof, 1);
        chk("post_rst_pixel", pix, 8'hFF);

        // Threshold boundaries
        send_one(8'd0, 8'd0, 8'd0, 8'd0, pix, sof, lat);
        chk("thr0_black", pix, 8'hFF);
        send_one(8'd254, 8'd255, 8'd255, 8'd255, pix, sof, lat);
        chk("thr255_near", pix, 8'h00);
        send_one(8'd255, 8'd255, 8'd255, 8'd255, pix, sof, lat);
        chk("thr255_white", pix, 8'hFF);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
